// File: rtl/mlp_input_loader.sv
// mlp_input_loader: assembles a valid/ready sample stream into a frozen parallel MLP input frame
module mlp_input_loader #(
  parameter int S0_NUM = 8,
  parameter int DATA_WIDTH = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic signed [DATA_WIDTH-1:0] inp [S0_NUM],
  output logic                         enable,
  output logic                         busy,
  output logic                         frame_err
);
  localparam int IW = S0_NUM > 1 ? $clog2(S0_NUM) : 1;
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(S0_NUM - 1);
  localparam logic [CW-1:0] CLAST = CW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  typedef enum logic [1:0] {FILL, DROP, ISSUE, WAIT} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic err_pend, acc, at_last;
  always_comb begin
    at_last = idx == LAST;
    in_ready = !reset && (state == FILL || state == DROP);
    acc = in_valid && in_ready;
    enable = !reset && state == ISSUE;
    busy = !reset && (state != FILL || idx != '0);
    nxt = state;
    case (state)
      FILL:    nxt = acc && in_last ? ISSUE : acc && at_last ? DROP : FILL;
      DROP:    nxt = acc && in_last ? ISSUE : DROP;
      ISSUE:   nxt = SETTLE_CYCLES > 0 ? WAIT : FILL;
      default: nxt = cnt == CLAST ? FILL : WAIT;
    endcase
  end
  // a short frame is zero-padded on the same edge that stores its final beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      idx <= '0;
      cnt <= '0;
      err_pend <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < S0_NUM; i++) inp[i] <= '0;
    end else begin
      state <= nxt;
      if (state == FILL && acc) begin
        inp[idx] <= in_data;
        idx <= at_last ? idx : idx + 1'b1;
        err_pend <= err_pend | (in_last ^ at_last);
        for (int i = 0; i < S0_NUM; i++) if (in_last && IW'(i) > idx) inp[i] <= '0;
      end
      if (state == ISSUE) begin
        frame_err <= err_pend;
        err_pend <= 1'b0;
        idx <= '0;
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_mlp_input_loader.sv
// tb_mlp_input_loader: randomized frame stimulus checked against a frame-level reference model
module tb_mlp_input_loader;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_last = 0, in_ready, enable, busy, frame_err;
  logic signed [7:0] in_data = 0;
  logic signed [7:0] inp [8];
  logic v0 = 0, l0 = 0, ready0, en0, busy0, ferr0;
  logic signed [7:0] d0 = 0;
  logic signed [7:0] inp0 [8];
  int checks = 0, errors = 0;

  mlp_input_loader #(.S0_NUM(8), .DATA_WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .inp(inp), .enable(enable), .busy(busy), .frame_err(frame_err));
  mlp_input_loader #(.S0_NUM(8), .DATA_WIDTH(8), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(ready0), .in_data(d0),
    .in_last(l0), .inp(inp0), .enable(en0), .busy(busy0), .frame_err(ferr0));

  always #5 clk = ~clk;

  // frame = beats up to in_last; first 8 kept, rest zero; error unless exactly 8 beats
  function automatic void model(input int d[$], output logic signed [7:0] v[8], output logic e);
    for (int i = 0; i < 8; i++) v[i] = i < d.size() ? 8'(d[i]) : 8'sd0;
    e = d.size() != 8;
  endfunction

  task automatic send(input int d, input bit l, input int bub, inout int to);
    if (bub > 0) begin
      in_valid = 0;
      repeat ($urandom_range(bub, 0)) @(negedge clk);
    end
    in_valid = 1; in_data = 8'(d); in_last = l;
    for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
    if (!in_ready) to++;
    @(negedge clk);
  endtask

  task automatic run_frame(input int d[$], input int bub, input bit hold,
                           output logic signed [7:0] got[8], output bit en_ok,
                           output int rdy_low, output bit stable, output bit dbl, output int to);
    to = 0;
    foreach (d[k]) send(d[k], k == d.size() - 1, bub, to);
    en_ok = enable;
    for (int i = 0; i < 8; i++) got[i] = inp[i];
    in_valid = hold; in_last = 0; in_data = 8'sh55;
    rdy_low = 0; stable = 1; dbl = 0;
    while (!in_ready && rdy_low < 50) begin
      rdy_low++;
      for (int i = 0; i < 8; i++) if (inp[i] !== got[i]) stable = 0;
      if (rdy_low > 1 && enable) dbl = 1;
      @(negedge clk);
    end
    if (enable) dbl = 1;
    if (rdy_low >= 50) to++;
    in_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    @(negedge clk);
    checks++; if (in_ready !== 0 || ready0 !== 0) begin errors++; $display("FAIL reset_ready got %b/%b want 0/0", in_ready, ready0); end
    checks++; if (enable !== 0 || busy !== 0) begin errors++; $display("FAIL reset_en_busy got %b/%b want 0/0", enable, busy); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++; if (inp[i] !== 0) begin errors++; $display("FAIL reset_inp[%0d] got %0d want 0", i, inp[i]); end
    end
    checks++; if (frame_err !== 0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    reset = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1 || busy !== 0) begin errors++; $display("FAIL post_reset got ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_frames(input string name, input int n, input int bub, input bit hold, input bit directed);
    int d[$];
    logic signed [7:0] got[8], ev[8];
    logic ee;
    bit en_ok, stable, dbl;
    int rdy_low, to, len;
    for (int f = 0; f < n; f++) begin
      d = {};
      if (directed && f == 0) for (int i = 1; i <= 8; i++) d.push_back(i);
      else if (directed && f == 1) begin d.push_back(-5); d.push_back(127); d.push_back(-128); end
      else if (directed) for (int i = 10; i <= 19; i++) d.push_back(i);
      else begin
        len = f == 0 ? 8 : int'($urandom_range(11, 1));
        for (int i = 0; i < len; i++) d.push_back(int'($urandom_range(255, 0)) - 128);
      end
      model(d, ev, ee);
      run_frame(d, bub, hold, got, en_ok, rdy_low, stable, dbl, to);
      checks++; if (to != 0) begin errors++; $display("FAIL %s f%0d timeout got %0d want 0", name, f, to); end
      checks++; if (en_ok !== 1) begin errors++; $display("FAIL %s f%0d enable_latency got %b want 1", name, f, en_ok); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (got[i] !== ev[i]) begin errors++; $display("FAIL %s f%0d inp[%0d] got %0d want %0d", name, f, i, got[i], ev[i]); end
      end
      checks++; if (frame_err !== ee) begin errors++; $display("FAIL %s f%0d frame_err got %b want %b", name, f, frame_err, ee); end
      checks++; if (rdy_low != 5) begin errors++; $display("FAIL %s f%0d ready_low got %0d want 5", name, f, rdy_low); end
      checks++; if (!stable) begin errors++; $display("FAIL %s f%0d inp_stable got 0 want 1", name, f); end
      checks++; if (dbl) begin errors++; $display("FAIL %s f%0d extra_enable got 1 want 0", name, f); end
      checks++; if (busy !== 0) begin errors++; $display("FAIL %s f%0d busy got %b want 0", name, f, busy); end
    end
  endtask

  task automatic test_reset_mid();
    int to = 0, bad = 0;
    bit saw = 0;
    for (int i = 0; i < 4; i++) send(int'($urandom_range(255, 0)) - 128, 0, 0, to);
    in_valid = 0;
    checks++; if (busy !== 1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    reset = 1;
    @(negedge clk);
    checks++; if (in_ready !== 0 || enable !== 0) begin errors++; $display("FAIL mid_reset got ready=%b en=%b want 0/0", in_ready, enable); end
    reset = 0;
    repeat (10) begin
      @(negedge clk);
      if (enable) saw = 1;
    end
    for (int i = 0; i < 8; i++) if (inp[i] !== 0) bad++;
    checks++; if (saw) begin errors++; $display("FAIL mid_no_enable got 1 want 0"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_inp_zero got %0d nonzero want 0", bad); end
    checks++; if (busy !== 0 || frame_err !== 0) begin errors++; $display("FAIL mid_state got busy=%b ferr=%b want 0/0", busy, frame_err); end
    checks++; if (to != 0) begin errors++; $display("FAIL mid_timeout got %0d want 0", to); end
    test_frames("post_reset", 1, 0, 0, 0);
  endtask

  task automatic test_settle0();
    int data[16];
    int k = 0, e1 = -1, e2 = -1, pulses = 0, bad = 0;
    bit prev = 0, rdy_ok = 1, dbl = 0;
    for (int i = 0; i < 16; i++) data[i] = int'($urandom_range(255, 0)) - 128;
    for (int c = 0; c < 80 && e2 < 0; c++) begin
      if (prev && !ready0) rdy_ok = 0;
      if (prev && en0) dbl = 1;
      if (en0) begin
        pulses++;
        if (e1 < 0) e1 = c; else e2 = c;
      end
      prev = en0;
      if (ready0 && k < 16) begin
        v0 = 1; d0 = 8'(data[k]); l0 = k % 8 == 7; k++;
      end else if (k >= 16) v0 = 0;
      @(negedge clk);
    end
    v0 = 0;
    if (!ready0) rdy_ok = 0;
    for (int i = 0; i < 8; i++) if (inp0[i] !== 8'(data[8 + i])) bad++;
    checks++; if (e2 < 0) begin errors++; $display("FAIL s0_timeout got e1=%0d e2=%0d want both >=0", e1, e2); end
    checks++; if (e2 - e1 != 9) begin errors++; $display("FAIL s0_spacing got %0d want 9", e2 - e1); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL s0_pulses got %0d want 2", pulses); end
    checks++; if (!rdy_ok) begin errors++; $display("FAIL s0_ready_after_enable got 0 want 1"); end
    checks++; if (dbl) begin errors++; $display("FAIL s0_double_enable got 1 want 0"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL s0_inp got %0d mismatches want 0", bad); end
    checks++; if (ferr0 !== 0 || busy0 !== 0) begin errors++; $display("FAIL s0_state got ferr=%b busy=%b want 0/0", ferr0, busy0); end
  endtask

  initial begin
    test_reset();
    test_frames("directed", 3, 0, 0, 1);
    test_frames("bubbles", 6, 3, 1, 0);
    test_reset_mid();
    test_settle0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
